// File: rtl/calc_pkg.sv
// Shared opcodes, state encoding and helpers for the parametrised calculator.
package calc_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_MUL = 3'd4;
  localparam logic [2:0] OP_DIV = 3'd5;
  localparam logic [2:0] OP_MOD = 3'd6;
  localparam logic [2:0] OP_RSV = 3'd7;

  // Encoding doubles as the CS debug code.
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LOAD_A = 4'd1,
    S_LOAD_B = 4'd2,
    S_EXEC   = 4'd3,
    S_STEP   = 4'd4,
    S_WB     = 4'd5,
    S_DONE   = 4'd6
  } state_t;

  // Iterative ops retire one result bit per cycle.
  function automatic int unsigned iter_count(input int unsigned width);
    return width;
  endfunction

endpackage

// File: rtl/param_calc_iter.sv
// Bit-serial engine for MUL (shift-add) and DIV/MOD (restoring divide).
module param_calc_iter
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNTW  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  logic [CNTW-1:0]  cnt,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             busy
);

  // MUL: hi:lo is the running product, opnd the multiplicand.
  // DIV/MOD: hi is the partial remainder, lo shifts dividend out / quotient in, opnd the divisor.
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  // Next-state for one start or one iteration step.
  always_comb begin
    op_d    = op_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    shifted = {hi_q, lo_q[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, opnd_q};
    if (start) begin
      op_d   = op;
      busy_d = 1'b1;
      hi_d   = '0;
      if (op == OP_MUL) begin
        opnd_d = a;
        lo_d   = b;
      end else begin
        opnd_d = b;
        lo_d   = a;
      end
    end else if (step && busy_q) begin
      if (op_q == OP_MUL) begin
        hi_d = sum[WIDTH:1];
        lo_d = {sum[0], lo_q[WIDTH-1:1]};
      end else if (!diff[WIDTH+1]) begin
        hi_d = diff[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = shifted[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
      if (cnt == CNTW'(1)) busy_d = 1'b0;
    end
  end

  // Iteration registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= '0;
      opnd_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
    end else begin
      op_q   <= op_d;
      opnd_q <= opnd_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      busy_q <= busy_d;
    end
  end

  assign result = (op_q == OP_MOD) ? hi_q : lo_q;
  assign ovf    = (op_q == OP_MUL) && (|hi_q);
  assign busy   = busy_q;

endmodule

// File: rtl/param_calculator.sv
// Multi-cycle calculator: control FSM, operand registers and single-cycle ALU.
module param_calculator
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Go,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  output logic [WIDTH-1:0] Out,
  output logic [3:0]       CS,
  output logic             Done,
  output logic             Ovf,
  output logic             Err
);

  localparam int unsigned CNTW = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  // Staged single-cycle result, consumed in WB when the iterator was not used.
  logic [WIDTH-1:0] res_q, res_d;
  logic             rovf_q, rovf_d;
  logic             rerr_q, rerr_d;
  logic             use_iter_q, use_iter_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic [WIDTH:0]   alu_sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             alu_err;
  logic             iter_ok;
  logic             iter_start;
  logic             iter_step;
  logic [WIDTH-1:0] iter_res;
  logic             iter_ovf;
  logic             iter_busy;

  // Divide by zero takes the single-cycle error path instead of iterating.
  assign iter_ok = (op_q == OP_MUL) ||
                   (((op_q == OP_DIV) || (op_q == OP_MOD)) && (b_q != '0));

  // Single-cycle ALU and error results.
  always_comb begin
    alu_sum = {1'b0, a_q} + {1'b0, b_q};
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_err = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res = alu_sum[WIDTH-1:0];
        alu_ovf = alu_sum[WIDTH];
      end
      OP_SUB: begin
        alu_res = a_q - b_q;
        alu_ovf = (a_q < b_q);
      end
      OP_AND: alu_res = a_q & b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_DIV: begin
        alu_res = '1;
        alu_err = 1'b1;
      end
      OP_MOD: begin
        alu_res = a_q;
        alu_err = 1'b1;
      end
      OP_RSV: alu_err = 1'b1;
      default: ;
    endcase
  end

  // Control FSM next-state, register loads and iterator strobes.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    res_d      = res_q;
    rovf_d     = rovf_q;
    rerr_d     = rerr_q;
    use_iter_d = use_iter_q;
    out_d      = out_q;
    ovf_d      = ovf_q;
    err_d      = err_q;
    iter_start = 1'b0;
    iter_step  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Go) begin
          op_d    = Op;
          state_d = S_LOAD_A;
        end
      end
      S_LOAD_A: begin
        a_d     = In1;
        state_d = S_LOAD_B;
      end
      S_LOAD_B: begin
        b_d     = In2;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d      = alu_res;
        rovf_d     = alu_ovf;
        rerr_d     = alu_err;
        use_iter_d = iter_ok;
        if (iter_ok) begin
          iter_start = 1'b1;
          cnt_d      = CNTW'(iter_count(WIDTH));
          state_d    = S_STEP;
        end else begin
          state_d = S_WB;
        end
      end
      S_STEP: begin
        iter_step = iter_busy;
        cnt_d     = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) state_d = S_WB;
      end
      S_WB: begin
        if (use_iter_q) begin
          out_d = iter_res;
          ovf_d = iter_ovf;
          err_d = 1'b0;
        end else begin
          out_d = res_q;
          ovf_d = rovf_q;
          err_d = rerr_q;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!Go) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      res_q      <= '0;
      rovf_q     <= 1'b0;
      rerr_q     <= 1'b0;
      use_iter_q <= 1'b0;
      out_q      <= '0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
      res_q      <= res_d;
      rovf_q     <= rovf_d;
      rerr_q     <= rerr_d;
      use_iter_q <= use_iter_d;
      out_q      <= out_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
    end
  end

  param_calc_iter #(
    .WIDTH (WIDTH),
    .CNTW  (CNTW)
  ) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (iter_start),
    .step   (iter_step),
    .cnt    (cnt_q),
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (iter_res),
    .ovf    (iter_ovf),
    .busy   (iter_busy)
  );

  assign Out  = out_q;
  assign CS   = state_q;
  assign Done = (state_q == S_DONE);
  assign Ovf  = ovf_q;
  assign Err  = err_q;

endmodule

// File: tb/tb_param_calculator.sv
// Self-checking bench: per-cycle compare against a timeline/result model.
module tb_param_calculator;

  localparam int W = 4;
  localparam int M = (1 << W) - 1;

  logic         clk;
  logic         rst;
  logic         Go;
  logic [2:0]   Op;
  logic [W-1:0] In1;
  logic [W-1:0] In2;
  logic [W-1:0] Out;
  logic [3:0]   CS;
  logic         Done;
  logic         Ovf;
  logic         Err;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Expected outputs, updated by the driver right after each active edge.
  int exp_cs   = 0;
  int exp_out  = 0;
  int exp_ovf  = 0;
  int exp_err  = 0;
  int exp_done = 0;

  param_calculator #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .Go   (Go),
    .Op   (Op),
    .In1  (In1),
    .In2  (In2),
    .Out  (Out),
    .CS   (CS),
    .Done (Done),
    .Ovf  (Ovf),
    .Err  (Err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Result model straight from the opcode definitions.
  task automatic model(input int op, input int a, input int b,
                       output int r, output int ov, output int er);
    longint p;
    r = 0; ov = 0; er = 0;
    case (op)
      0: begin r = (a + b) & M; ov = (a + b > M) ? 1 : 0; end
      1: begin r = (a - b) & M; ov = (a < b) ? 1 : 0; end
      2: r = a & b;
      3: r = a ^ b;
      4: begin p = longint'(a) * longint'(b); r = int'(p) & M; ov = ((p >> W) != 0) ? 1 : 0; end
      5: if (b == 0) begin r = M; er = 1; end else r = a / b;
      6: if (b == 0) begin r = a; er = 1; end else r = a % b;
      default: begin r = 0; er = 1; end
    endcase
  endtask

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cs",   int'(CS),   exp_cs);
      chk("out",  int'(Out),  exp_out);
      chk("ovf",  int'(Ovf),  exp_ovf);
      chk("err",  int'(Err),  exp_err);
      chk("done", int'(Done), exp_done);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction from IDLE; hold = extra DONE cycles with Go still high.
  task automatic run_op(input int op, input int a, input int b, input int hold);
    int r, ov, er;
    bit iter;
    model(op, a, b, r, ov, er);
    iter = (op == 4) || (((op == 5) || (op == 6)) && (b != 0));
    Op = 3'(op); In1 = W'(a); In2 = W'(b); Go = 1'b1;
    tick(); exp_cs = 1;
    Op = 3'($urandom); Go = 1'($urandom);
    tick(); exp_cs = 2;
    In1 = W'($urandom);
    tick(); exp_cs = 3;
    In2 = W'($urandom);
    if (iter) begin
      for (int i = 0; i < W; i++) begin
        tick(); exp_cs = 4;
        Go = 1'($urandom);
      end
    end
    tick(); exp_cs = 5;
    Go = 1'($urandom);
    tick(); exp_cs = 6; exp_done = 1;
    exp_out = r; exp_ovf = ov; exp_err = er;
    for (int i = 0; i < hold; i++) begin
      Go = 1'b1; Op = 3'($urandom);
      tick();
    end
    Go = 1'b0;
    tick(); exp_cs = 0; exp_done = 0;
  endtask

  task automatic idle(input int n);
    Go = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int r, ov, er;
    int op, a, b;
    rst = 1'b1; Go = 1'b0; Op = '0; In1 = '0; In2 = '0;
    chk_en = 1'b1;

    // Pin the model with hand-computed values.
    model(0, 9, 5, r, ov, er);   chk("model_add", r, 14); chk("model_add_ovf", ov, 0);
    model(0, 12, 7, r, ov, er);  chk("model_add2", r, 3); chk("model_add2_ovf", ov, 1);
    model(1, 3, 5, r, ov, er);   chk("model_sub", r, 14); chk("model_sub_ovf", ov, 1);
    model(4, 6, 3, r, ov, er);   chk("model_mul", r, 2);  chk("model_mul_ovf", ov, 1);
    model(5, 13, 4, r, ov, er);  chk("model_div", r, 3);
    model(6, 13, 4, r, ov, er);  chk("model_mod", r, 1);
    model(5, 7, 0, r, ov, er);   chk("model_div0", r, 15); chk("model_div0_err", er, 1);

    #23 rst = 1'b0;
    tick();

    // Directed scenarios.
    run_op(0, 9, 5, 0);
    run_op(0, 12, 7, 0);
    run_op(1, 3, 5, 0);
    run_op(2, 12, 10, 0);
    run_op(3, 12, 10, 0);
    run_op(4, 3, 5, 0);
    run_op(4, 6, 3, 0);
    run_op(5, 13, 4, 0);
    run_op(6, 13, 4, 0);
    run_op(5, 7, 0, 0);
    run_op(7, 9, 9, 0);
    run_op(0, 2, 3, 3);
    idle(2);

    // Reset mid-STEP of MUL 6*3: outputs clear at once, no writeback.
    Op = 3'd4; In1 = 4'd6; In2 = 4'd3; Go = 1'b1;
    tick(); exp_cs = 1; Go = 1'b0;
    tick(); exp_cs = 2;
    tick(); exp_cs = 3;
    tick(); exp_cs = 4;
    tick(); exp_cs = 4;
    #2;
    rst = 1'b1;
    exp_cs = 0; exp_out = 0; exp_ovf = 0; exp_err = 0; exp_done = 0;
    #1;
    chk("rst_cs", int'(CS), 0);
    chk("rst_out", int'(Out), 0);
    chk("rst_done", int'(Done), 0);
    @(negedge clk);
    #1 rst = 1'b0;
    tick();
    run_op(0, 1, 1, 0);
    chk("post_rst_add", int'(Out), 2);

    // Randomised traffic, biased toward divide by zero and back-to-back starts.
    for (int n = 0; n < 150; n++) begin
      op = int'($urandom_range(0, 7));
      a  = int'($urandom_range(0, M));
      b  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, M));
      run_op(op, a, b, int'($urandom_range(0, 2)));
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end

    idle(2);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
